// File: rtl/ps_pkg.sv
// -----------------------------------------------------------------------------
// ps_pkg
// Shared constants and types for the PCIe PHY transmit lane arbiter.
//   IDLE_SYM  : K28.5 COM symbol sent while no data byte is scheduled
//   SLOT_W    : width of the slot counter (matches serializer bit selector)
//   SLOT_LAST : byte boundary slot, the only slot where arbitration happens
//   state_t   : arbiter state, IDLE (free to arbitrate) or BURST (grant locked)
// -----------------------------------------------------------------------------
package ps_pkg;

   localparam logic [7:0] IDLE_SYM = 8'hBC;

   localparam int SLOT_W = 3;
   localparam logic [SLOT_W-1:0] SLOT_LAST = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/ps_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ps_rr_arbiter
// Combinational round-robin search: finds the first asserted request starting
// at i_rr_ptr and moving upward, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   i_req    [NUM_REQ-1:0] : request vector
//   i_rr_ptr [IDX_W-1:0]   : index searched first
//   o_hit                  : at least one request is asserted
//   o_grant  [IDX_W-1:0]   : index of the first asserted request (0 if no hit)
// -----------------------------------------------------------------------------
module ps_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic               o_hit,
   output logic [IDX_W-1:0]   o_grant
);

   int w_idx;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers latches.
   always_comb begin
      o_hit   = 1'b0;
      o_grant = '0;
      w_idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = int'(i_rr_ptr) + i;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         // First hit in search order wins; later hits are ignored.
         if (!o_hit && i_req[IDX_W'(w_idx)]) begin
            o_hit   = 1'b1;
            o_grant = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/ps_lane_arbiter.sv
// -----------------------------------------------------------------------------
// ps_lane_arbiter
// Shares one paralelo_a_serial serializer between NUM_REQ byte requesters.
// A 3-bit slot counter runs in lockstep with the serializer's bit selector;
// arbitration and byte loading happen only in slot 7 so each byte stays on
// ser_data for exactly 8 clk32f cycles. Multi-byte bursts (req_last=0) lock
// the grant until the last byte. With nothing to send, ser_valid=0 and
// ser_data carries IDLE_SYM.
// Ports:
//   clk32f      : bit clock shared with the serializer
//   reset       : synchronous, active-low
//   req_valid   : per-requester byte valid
//   req_data    : per-requester byte, requester i at [8i+7:8i]
//   req_last    : byte is last of its burst
//   req_ready   : one-cycle accept pulse (slot 7 only)
//   ser_data    : byte to serializer
//   ser_valid   : serializer in_valid
//   byte_strobe : high during slot 7
//   grant_id    : requester owning the current byte
//   busy        : high while a burst holds the grant
// Optional build macro PS_ARB_UNDERRUN_CNT_EN adds:
//   underrun_clr : synchronous clear of underrun_cnt (wins over increment)
//   underrun_cnt : saturating count of burst underruns at slot 7
// -----------------------------------------------------------------------------
module ps_lane_arbiter #(
   parameter  int         NUM_REQ  = 4,
   parameter  logic [7:0] IDLE_SYM = 8'hBC,
   localparam int         IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk32f,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           ser_data,
   output logic                 ser_valid,
   output logic                 byte_strobe,
   output logic [IDX_W-1:0]     grant_id,
`ifdef PS_ARB_UNDERRUN_CNT_EN
   input  logic                 underrun_clr,
   output logic [15:0]          underrun_cnt,
`endif
   output logic                 busy
);

   import ps_pkg::state_t, ps_pkg::IDLE, ps_pkg::BURST;
   import ps_pkg::SLOT_W, ps_pkg::SLOT_LAST;

   logic [SLOT_W-1:0] r_slot;
   state_t            r_state;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [IDX_W-1:0]  r_grant;
   logic [7:0]        r_ser_data;
   logic              r_ser_valid;

   logic              w_boundary;
   logic              w_hit;
   logic [IDX_W-1:0]  w_arb_idx;
   logic [IDX_W-1:0]  w_sel_idx;
   logic              w_sel_valid;
   logic              w_accept;
   logic [7:0]        w_sel_data;
   logic              w_sel_last;
   logic [IDX_W-1:0]  w_next_ptr;

   ps_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .i_req    (req_valid),
      .i_rr_ptr (r_rr_ptr),
      .o_hit    (w_hit),
      .o_grant  (w_arb_idx)
   );

   assign w_boundary = (r_slot == SLOT_LAST);

   // In BURST the grant is locked: only the owner is looked at.
   assign w_sel_idx   = (r_state == BURST) ? r_grant : w_arb_idx;
   assign w_sel_valid = (r_state == BURST) ? req_valid[r_grant] : w_hit;
   assign w_sel_data  = req_data[{w_sel_idx, 3'b000} +: 8];
   assign w_sel_last  = req_last[w_sel_idx];
   assign w_next_ptr  = (w_sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;

   // Gated by reset so a requester never sees ready in a cycle whose
   // transfer the reset throws away.
   assign w_accept = w_boundary & w_sel_valid & reset;

   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_sel_idx] = 1'b1;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the values from before the clock edge.
   always_ff @(posedge clk32f) begin
      if (!reset) begin
         r_slot      <= '0;
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_ser_data  <= IDLE_SYM;
         r_ser_valid <= 1'b0;
      end else begin
         r_slot <= r_slot + 1'b1;
         if (w_boundary) begin
            if (w_accept) begin
               r_ser_data  <= w_sel_data;
               r_ser_valid <= 1'b1;
               r_grant     <= w_sel_idx;
               if (w_sel_last) begin
                  r_state  <= IDLE;
                  r_rr_ptr <= w_next_ptr;
               end else begin
                  r_state  <= BURST;
               end
            end else begin
               // No hit in IDLE, or underrun in BURST: grant and state hold.
               r_ser_data  <= IDLE_SYM;
               r_ser_valid <= 1'b0;
            end
         end
      end
   end

   assign ser_data    = r_ser_data;
   assign ser_valid   = r_ser_valid;
   assign grant_id    = r_grant;
   assign busy        = (r_state == BURST);
   assign byte_strobe = w_boundary;

`ifdef PS_ARB_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;
   logic        w_underrun;

   assign w_underrun = w_boundary & (r_state == BURST) & ~req_valid[r_grant];

   always_ff @(posedge clk32f) begin
      if (!reset) begin
         r_underrun_cnt <= '0;
      end else if (underrun_clr) begin
         r_underrun_cnt <= '0;
      end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_ps_lane_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ps_lane_arbiter
// Self-checking bench for ps_lane_arbiter (NUM_REQ=4). Requesters are modelled
// as byte queues; a behavioural reference tracks cycle position, burst owner
// and round-robin pointer and predicts every output each cycle. Directed
// scenarios pin the model with literal expectations, then a randomized run
// exercises bursts, underruns and arbitration. Build with
// PS_ARB_UNDERRUN_CNT_EN defined to also cover the underrun counter.
// -----------------------------------------------------------------------------
module tb_ps_lane_arbiter;

   localparam int         N    = 4;
   localparam logic [7:0] IDLE = 8'hBC;

   logic           clk32f = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     ser_data;
   logic           ser_valid;
   logic           byte_strobe;
   logic [1:0]     grant_id;
   logic           busy;
`ifdef PS_ARB_UNDERRUN_CNT_EN
   logic           underrun_clr;
   logic [15:0]    underrun_cnt;
`endif

   always #5 clk32f = ~clk32f;

   ps_lane_arbiter #(
      .NUM_REQ  (N),
      .IDLE_SYM (IDLE)
   ) dut (
      .clk32f      (clk32f),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .ser_data    (ser_data),
      .ser_valid   (ser_valid),
      .byte_strobe (byte_strobe),
      .grant_id    (grant_id),
`ifdef PS_ARB_UNDERRUN_CNT_EN
      .underrun_clr(underrun_clr),
      .underrun_cnt(underrun_cnt),
`endif
      .busy        (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Requester side: per-requester byte queues {last, data} and a per-requester
   // "hold valid low" flag used to create underruns.
   logic [8:0] qb [N][8];
   int         qh [N];
   int         qn [N];
   bit         p_low [N];

   task automatic push(input int i, input logic last, input logic [7:0] d);
      qb[i][(qh[i] + qn[i]) % 8] = {last, d};
      qn[i]++;
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) begin
         qh[i] = 0; qn[i] = 0; p_low[i] = 1'b0;
      end
   endtask

   task automatic drive();
      logic [8:0] v;
      for (int i = 0; i < N; i++) begin
         if (qn[i] > 0) begin
            v = qb[i][qh[i]];
            req_data[8*i +: 8] = v[7:0];
            req_last[i]        = v[8];
            req_valid[i]       = !p_low[i];
         end else begin
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i]        = 1'($urandom);
            req_valid[i]       = 1'b0;
         end
      end
   endtask

   // Behavioural reference: position in the byte, burst owner (-1 = none),
   // round-robin start, and what the serializer is currently being fed.
   int         m_cyc, m_slot, m_owner, m_ptr, m_grant, m_cnt;
   logic [7:0] m_data;
   logic       m_valid;
   bit         m_known = 1'b0;
   int         strobe_cnt;

   // Requester accepted in the current cycle, or -1.
   function automatic int m_pick();
      int j;
      if (!reset || m_slot != 7) return -1;
      if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
      for (int i = 0; i < N; i++) begin
         j = (m_ptr + i) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_update();
      int k;
      k = m_pick();
      if (!reset) begin
         m_cyc = 0; m_slot = 0; m_owner = -1; m_ptr = 0; m_grant = 0;
         m_data = IDLE; m_valid = 1'b0; m_cnt = 0; m_known = 1'b1;
         return;
      end
      if (m_slot == 7) begin
         if (k >= 0) begin
            m_data  = qb[k][qh[k]][7:0];
            m_valid = 1'b1;
            m_grant = k;
            if (qb[k][qh[k]][8]) begin
               m_owner = -1;
               m_ptr   = (k + 1) % N;
            end else begin
               m_owner = k;
            end
            qh[k] = (qh[k] + 1) % 8;
            qn[k]--;
         end else begin
            m_data  = IDLE;
            m_valid = 1'b0;
            if (m_owner >= 0 && m_cnt < 16'hFFFF) m_cnt++;
         end
      end
`ifdef PS_ARB_UNDERRUN_CNT_EN
      if (underrun_clr) m_cnt = 0;
`endif
      m_slot = (m_slot + 1) % 8;
      m_cyc++;
   endtask

   task automatic compare();
      int         k;
      logic [N-1:0] er;
      if (!m_known) return;
      k  = m_pick();
      er = '0;
      if (k >= 0) er[k] = 1'b1;
      check("req_ready",   32'(req_ready),   32'(er));
      check("ser_data",    32'(ser_data),    32'(m_data));
      check("ser_valid",   32'(ser_valid),   32'(m_valid));
      check("byte_strobe", 32'(byte_strobe), 32'(m_slot == 7));
      check("grant_id",    32'(grant_id),    32'(m_grant));
      check("busy",        32'(busy),        32'(m_owner >= 0));
`ifdef PS_ARB_UNDERRUN_CNT_EN
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
      if (byte_strobe === 1'b1) strobe_cnt++;
   endtask

   // One clock cycle: drive, compare at the falling edge, advance the model
   // at the rising edge, then step clear of the edge.
   task automatic tick();
      drive();
      @(negedge clk32f);
      compare();
      @(posedge clk32f);
      model_update();
      #1;
   endtask

   task automatic run_until(input int c);
      int guard = 0;
      while (m_cyc < c && guard < 1000) begin
         tick();
         guard++;
      end
      if (guard >= 1000) check("run_until_budget", 32'(m_cyc), 32'(c));
   endtask

   task automatic reset_dut();
      clear_q();
`ifdef PS_ARB_UNDERRUN_CNT_EN
      underrun_clr = 1'b0;
`endif
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic refill_until(input logic [N-1:0] act, input int c);
      int guard = 0;
      while (m_cyc < c && guard < 1000) begin
         for (int i = 0; i < N; i++)
            if (act[i] && qn[i] == 0) push(i, 1'b1, 8'(8'h10 * i + m_cyc));
         tick();
         guard++;
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      clear_q();

      // Idle: no requests for 32 cycles.
      reset_dut();
      strobe_cnt = 0;
      run_until(32);
      check("idle_strobes", 32'(strobe_cnt), 32'd4);
      check("idle_data", 32'(ser_data), 32'hBC);
      check("idle_valid", 32'(ser_valid), 32'd0);

      // Single byte A5 from requester 0 offered at cycle 3.
      reset_dut();
      run_until(3);
      push(0, 1'b1, 8'hA5);
      run_until(6);
      tick();
      drive();
      #1;
      check("a5_ready_slot7", 32'(req_ready), 32'h1);
      run_until(8);
      check("a5_data_c8", 32'(ser_data), 32'hA5);
      check("a5_valid_c8", 32'(ser_valid), 32'd1);
      check("a5_busy_c8", 32'(busy), 32'd0);
      run_until(15);
      check("a5_data_c15", 32'(ser_data), 32'hA5);
      run_until(16);
      check("a5_idle_c16", 32'(ser_data), 32'hBC);

      // Requesters 1 and 2 continuously valid, then all four.
      reset_dut();
      refill_until(4'b0110, 8);  check("rr_g8",  32'(grant_id), 32'd1);
      refill_until(4'b0110, 16); check("rr_g16", 32'(grant_id), 32'd2);
      refill_until(4'b0110, 24); check("rr_g24", 32'(grant_id), 32'd1);
      refill_until(4'b0110, 32); check("rr_g32", 32'(grant_id), 32'd2);
      refill_until(4'b1111, 40); check("rr_g40", 32'(grant_id), 32'd3);
      refill_until(4'b1111, 48); check("rr_g48", 32'(grant_id), 32'd0);
      refill_until(4'b1111, 56); check("rr_g56", 32'(grant_id), 32'd1);

      // Three-byte burst from requester 0 while requester 1 waits.
      reset_dut();
      push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h22); push(0, 1'b1, 8'h33);
      push(1, 1'b1, 8'h44);
      run_until(8);  check("burst_d8",  32'(ser_data), 32'h11); check("burst_busy8",  32'(busy), 32'd1);
      run_until(16); check("burst_d16", 32'(ser_data), 32'h22); check("burst_busy16", 32'(busy), 32'd1);
      run_until(24); check("burst_d24", 32'(ser_data), 32'h33); check("burst_busy24", 32'(busy), 32'd0);
      run_until(32); check("burst_d32", 32'(ser_data), 32'h44); check("burst_g32",    32'(grant_id), 32'd1);

      // Underrun inside a burst.
      reset_dut();
      push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22);
      push(1, 1'b1, 8'h44);
      run_until(8);
      p_low[0] = 1'b1;
      run_until(16);
      p_low[0] = 1'b0;
      check("ur_valid16", 32'(ser_valid), 32'd0);
      check("ur_data16",  32'(ser_data),  32'hBC);
      check("ur_busy16",  32'(busy),      32'd1);
`ifdef PS_ARB_UNDERRUN_CNT_EN
      check("ur_cnt16",   32'(underrun_cnt), 32'd1);
`endif
      run_until(24); check("ur_d24", 32'(ser_data), 32'h22); check("ur_g24", 32'(grant_id), 32'd0);
      run_until(32); check("ur_d32", 32'(ser_data), 32'h44);

      // Reset in slot 4 of a burst owned by requester 2.
      reset_dut();
      push(1, 1'b1, 8'h44);
      push(2, 1'b0, 8'h55); push(2, 1'b0, 8'h66); push(2, 1'b1, 8'h67);
      run_until(16);
      check("mr_d16", 32'(ser_data), 32'h55); check("mr_g16", 32'(grant_id), 32'd2);
      run_until(20);
      reset = 1'b0;
      tick();
      check("mr_rst_data",  32'(ser_data),    32'hBC);
      check("mr_rst_valid", 32'(ser_valid),   32'd0);
      check("mr_rst_busy",  32'(busy),        32'd0);
      check("mr_rst_grant", 32'(grant_id),    32'd0);
      check("mr_rst_strb",  32'(byte_strobe), 32'd0);
      reset = 1'b1;
      push(0, 1'b1, 8'h77);
      run_until(8);  check("mr_d8",  32'(ser_data), 32'h77); check("mr_g8",  32'(grant_id), 32'd0);
      run_until(16); check("mr_d16b", 32'(ser_data), 32'h66); check("mr_busy16b", 32'(busy), 32'd1);

      // Randomized traffic.
      reset_dut();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (qn[i] == 0 && $urandom_range(0, 2) == 0)
               push(i, 1'($urandom_range(0, 1)), 8'($urandom));
            p_low[i] = ($urandom_range(0, 5) == 0);
         end
`ifdef PS_ARB_UNDERRUN_CNT_EN
         underrun_clr = ($urandom_range(0, 49) == 0);
`endif
         if ($urandom_range(0, 999) == 0) reset = 1'b0;
         else reset = 1'b1;
         tick();
      end
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
